// File: rtl/calc_sequencer.sv
// calc_sequencer: queues 23-bit instructions in a small FIFO and issues them
// one per cycle to a downstream calculator as registered control pulses.
// READ results are captured from the calculator's read bus into a
// valid/ready result register. A READ cannot issue while an earlier READ's
// result is still waiting to be taken.
module calc_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [22:0] in_instr,
  output logic        WEN,
  output logic [2:0]  RW,
  output logic [2:0]  RX,
  output logic [2:0]  RY,
  output logic [7:0]  DataIn,
  output logic        Sel,
  output logic [3:0]  Ctrl,
  input  logic [7:0]  busY,
  input  logic        Carry,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        carry_flag,
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] T_EXEC_D = 2'b00;
  localparam logic [1:0] T_EXEC_R = 2'b01;
  localparam logic [1:0] T_READ   = 2'b10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [22:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [1:0]    pres_type;
  logic          pres_valid;
  logic [22:0]   head;
  logic [1:0]    head_type;
  logic          push;
  logic          pop_ok;
  logic          pop;

  assign head       = mem[rd_ptr];
  assign head_type  = head[22:21];
  // An instruction is being presented exactly when the FSM sits in ISSUE.
  assign pres_valid = (state == S_ISSUE);

  assign in_ready = (count < CW'(DEPTH)) && !Rst;
  assign push     = in_valid && in_ready;
  // A READ may not issue while a result is still held, or while the
  // instruction currently presented is itself a READ about to capture.
  assign pop_ok   = !((head_type == T_READ) &&
                      (res_valid || (pres_valid && (pres_type == T_READ))));
  assign pop      = (count != '0) && pop_ok;
  assign busy     = (count != '0) || pres_valid;

  // FIFO storage write.
  // NOTE: storage carries no reset; valid entries are tracked by count and the pointers alone.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Next-state selection for the issue FSM.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = S_IDLE;
    if (pop)                state_next = S_ISSUE;
    else if (count != '0)   state_next = S_STALL;
  end

  // Issue FSM state register.
  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Calculator control outputs: loaded on a pop, otherwise returned to zero.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      WEN       <= 1'b0;
      Sel       <= 1'b0;
      RW        <= '0;
      RX        <= '0;
      RY        <= '0;
      Ctrl      <= '0;
      DataIn    <= '0;
      pres_type <= '0;
    end else begin
      WEN    <= 1'b0;
      Sel    <= 1'b0;
      RW     <= '0;
      RX     <= '0;
      RY     <= '0;
      Ctrl   <= '0;
      DataIn <= '0;
      if (pop) begin
        pres_type <= head_type;
        WEN       <= (head_type == T_EXEC_D) || (head_type == T_EXEC_R);
        Sel       <= (head_type == T_EXEC_R);
        RW        <= head[20:18];
        RX        <= head[17:15];
        RY        <= head[14:12];
        Ctrl      <= head[11:8];
        DataIn    <= (head_type == T_EXEC_D) ? head[7:0] : 8'h00;
      end
    end
  end

  // Result capture for READs and carry capture for EXEC instructions.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      carry_flag <= 1'b0;
    end else begin
      if (pres_valid && (pres_type == T_READ)) begin
        res_data  <= busY;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      if (pres_valid && !pres_type[1]) carry_flag <= Carry;
    end
  end

endmodule
